// File: rtl/io_port_bank_pkg.sv
// Shared constants, decode result type and address decoder for the GPIO/interrupt port bank.
package io_port_bank_pkg;

    localparam int unsigned PORT_W = 8;

    localparam logic [1:0] OFF_DATA  = 2'd0;
    localparam logic [1:0] OFF_DDR   = 2'd1;
    localparam logic [1:0] OFF_IFLAG = 2'd2;
    localparam logic [1:0] OFF_IEN   = 2'd3;

    localparam int unsigned CTRL_GIE   = 0;
    localparam int unsigned CTRL_SWNMI = 1;

    localparam int unsigned EDGE_FALL = 0;
    localparam int unsigned EDGE_RISE = 1;
    localparam int unsigned EDGE_BOTH = 2;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
        logic [1:0] off;
    } dec_t;

    // Legacy alias decodes as port 0 DATA; CTRL and its holes decode as idx == nports.
    function automatic dec_t decode(input logic [15:0] addr, input logic [15:0] base,
                                    input int unsigned nports, input logic leg_en,
                                    input logic [15:0] leg_addr);
        dec_t        d;
        logic [15:0] rel;
        d   = '0;
        rel = addr - base;
        if (leg_en && (addr == leg_addr)) begin
            d.hit = 1'b1;
        end else if (rel < 16'(4 * nports + 4)) begin
            d.hit = 1'b1;
            d.idx = rel[5:2];
            d.off = rel[1:0];
        end
        return d;
    endfunction

endpackage

// File: rtl/io_port_bank_channel.sv
// One 8-bit port: DATA/DDR/IFLAG/IEN registers, pin synchroniser, edge detect and flag logic.
module io_port_bank_channel
    import io_port_bank_pkg::*;
#(
    parameter int unsigned IRQ_EDGE = EDGE_RISE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              armed_i,
    input  logic              wr_en_i,
    input  logic [1:0]        wr_off_i,
    input  logic [PORT_W-1:0] wr_data_i,
    input  logic [PORT_W-1:0] pin_i,
    output logic [PORT_W-1:0] out_o,
    output logic [PORT_W-1:0] oe_o,
    output logic [PORT_W-1:0] iflag_o,
    output logic [PORT_W-1:0] ien_o,
    output logic [PORT_W-1:0] rd_data_o,
    output logic              irq_req_o
);

    logic [PORT_W-1:0] out_q, out_d, oe_q, oe_d, iflag_q, iflag_d, ien_q, ien_d;
    logic [PORT_W-1:0] s1_q, s2_q, prev_q;
    logic [PORT_W-1:0] w1c, rise, fall, edge_hit, set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            oe_q    <= '0;
            iflag_q <= '0;
            ien_q   <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
        end else begin
            out_q   <= out_d;
            oe_q    <= oe_d;
            iflag_q <= iflag_d;
            ien_q   <= ien_d;
            s1_q    <= pin_i;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
        end
    end

    // Register writes; a flag set in the same cycle as its W1C wins.
    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        ien_d = ien_q;
        w1c   = '0;
        if (wr_en_i) begin
            case (wr_off_i)
                OFF_DATA:  out_d = wr_data_i;
                OFF_DDR:   oe_d  = wr_data_i;
                OFF_IFLAG: w1c   = wr_data_i;
                default:   ien_d = wr_data_i;
            endcase
        end
        rise = s2_q & ~prev_q;
        fall = ~s2_q & prev_q;
        if (IRQ_EDGE == EDGE_FALL) begin
            edge_hit = fall;
        end else if (IRQ_EDGE == EDGE_RISE) begin
            edge_hit = rise;
        end else begin
            edge_hit = rise | fall;
        end
        set     = edge_hit & ~oe_q & {PORT_W{armed_i}};
        iflag_d = (iflag_q & ~w1c) | set;
    end

    assign out_o     = out_q;
    assign oe_o      = oe_q;
    assign iflag_o   = iflag_q;
    assign ien_o     = ien_q;
    assign rd_data_o = (out_q & oe_q) | (s2_q & ~oe_q);
    assign irq_req_o = |(iflag_q & ien_q);

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of NPORTS GPIO ports with CTRL register, legacy alias and irq/nmi outputs.
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int unsigned NPORTS      = 2,
    parameter logic [15:0] BASE        = 16'hbfe0,
    parameter bit          LEGACY_EN   = 1'b1,
    parameter logic [15:0] LEGACY_ADDR = 16'hbffc,
    parameter int unsigned IRQ_EDGE    = EDGE_RISE
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              address,
    input  logic [15:0]              address_next,
    input  logic                     write_next,
    input  logic                     ready,
    input  logic [7:0]               data_i,
    output logic [7:0]               data_o,
    output logic                     hit,
    input  logic [PORT_W*NPORTS-1:0] port_in,
    output logic [PORT_W*NPORTS-1:0] port_out,
    output logic [PORT_W*NPORTS-1:0] port_oe,
    output logic                     irq,
    output logic                     nmi
);

    logic [PORT_W-1:0] ch_out [NPORTS];
    logic [PORT_W-1:0] ch_oe [NPORTS];
    logic [PORT_W-1:0] ch_iflag [NPORTS];
    logic [PORT_W-1:0] ch_ien [NPORTS];
    logic [PORT_W-1:0] ch_rd [NPORTS];
    logic [NPORTS-1:0] ch_req;

    dec_t rd_dec, wr_dec;
    logic wr_commit, ctrl_wr;
    logic gie_q, gie_d, swnmi_q, swnmi_d, armed_q, armed_d, irq_q, irq_d, nmi_q, nmi_d;
    logic [1:0] arm_cnt_q, arm_cnt_d;
    logic [7:0] ctrl_rd;

    assign rd_dec    = decode(address, BASE, NPORTS, LEGACY_EN, LEGACY_ADDR);
    assign wr_dec    = decode(address_next, BASE, NPORTS, LEGACY_EN, LEGACY_ADDR);
    assign wr_commit = write_next & ready & wr_dec.hit;
    assign ctrl_wr   = wr_commit && (wr_dec.idx == 4'(NPORTS)) && (wr_dec.off == OFF_DATA);

    for (genvar p = 0; p < NPORTS; p++) begin : g_ch
        io_port_bank_channel #(.IRQ_EDGE(IRQ_EDGE)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .armed_i   (armed_q),
            .wr_en_i   (wr_commit && (wr_dec.idx == 4'(p))),
            .wr_off_i  (wr_dec.off),
            .wr_data_i (data_i),
            .pin_i     (port_in[p*PORT_W +: PORT_W]),
            .out_o     (ch_out[p]),
            .oe_o      (ch_oe[p]),
            .iflag_o   (ch_iflag[p]),
            .ien_o     (ch_ien[p]),
            .rd_data_o (ch_rd[p]),
            .irq_req_o (ch_req[p])
        );
        assign port_out[p*PORT_W +: PORT_W] = ch_out[p];
        assign port_oe[p*PORT_W +: PORT_W]  = ch_oe[p];
    end

    // Combinational read mux; holes and misses read zero.
    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd[CTRL_GIE]   = gie_q;
        ctrl_rd[CTRL_SWNMI] = swnmi_q;
        data_o              = '0;
        if (rd_dec.hit) begin
            if (rd_dec.idx == 4'(NPORTS)) begin
                if (rd_dec.off == OFF_DATA) data_o = ctrl_rd;
            end else begin
                for (int p = 0; p < int'(NPORTS); p++) begin
                    if (rd_dec.idx == 4'(p)) begin
                        case (rd_dec.off)
                            OFF_DATA:  data_o = ch_rd[p];
                            OFF_DDR:   data_o = ch_oe[p];
                            OFF_IFLAG: data_o = ch_iflag[p];
                            default:   data_o = ch_ien[p];
                        endcase
                    end
                end
            end
        end
    end
    assign hit = rd_dec.hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie_q     <= 1'b0;
            swnmi_q   <= 1'b0;
            arm_cnt_q <= 2'd0;
            armed_q   <= 1'b0;
            irq_q     <= 1'b0;
            nmi_q     <= 1'b0;
        end else begin
            gie_q     <= gie_d;
            swnmi_q   <= swnmi_d;
            arm_cnt_q <= arm_cnt_d;
            armed_q   <= armed_d;
            irq_q     <= irq_d;
            nmi_q     <= nmi_d;
        end
    end

    // Arming waits until the synchroniser and previous-value stage hold real pin data.
    always_comb begin
        gie_d     = gie_q;
        swnmi_d   = swnmi_q;
        arm_cnt_d = arm_cnt_q;
        armed_d   = armed_q | (arm_cnt_q == 2'd2);
        if (arm_cnt_q != 2'd2) arm_cnt_d = arm_cnt_q + 2'd1;
        if (ctrl_wr) begin
            gie_d   = data_i[CTRL_GIE];
            swnmi_d = data_i[CTRL_SWNMI];
        end
        irq_d = (gie_q & (|ch_req)) | (LEGACY_EN & ch_out[0][0]);
        nmi_d = swnmi_q | (LEGACY_EN & ch_out[0][1]);
    end

    assign irq = irq_q;
    assign nmi = nmi_q;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed self-checking bench for io_port_bank with default parameters (2 ports, BASE bfe0).
module tb_io_port_bank;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] address = 16'h0000;
    logic [15:0] address_next = 16'h0000;
    logic        write_next = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  data_o;
    logic        hit;
    logic [15:0] port_in = 16'h0000;
    logic [15:0] port_out;
    logic [15:0] port_oe;
    logic        irq;
    logic        nmi;

    int n_checks = 0;
    int n_pass   = 0;

    io_port_bank dut (
        .clk          (clk),
        .reset        (reset),
        .address      (address),
        .address_next (address_next),
        .write_next   (write_next),
        .ready        (ready),
        .data_i       (data_i),
        .data_o       (data_o),
        .hit          (hit),
        .port_in      (port_in),
        .port_out     (port_out),
        .port_oe      (port_oe),
        .irq          (irq),
        .nmi          (nmi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge: drives one bus write, commits on the next posedge, returns at the following negedge.
    task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic rdy);
        address_next = a;
        data_i       = d;
        write_next   = 1'b1;
        ready        = rdy;
        @(negedge clk);
        write_next   = 1'b0;
        ready        = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp_d, input logic exp_h, input string tag);
        address = a;
        #1;
        check(tag, 32'(data_o), 32'(exp_d));
        check({tag, "_hit"}, 32'(hit), 32'(exp_h));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out", 32'(port_out), 32'h0);
        check("rst_oe", 32'(port_oe), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_nmi", 32'(nmi), 32'h0);

        // Pins high while leaving reset must not look like an edge.
        port_in = 16'hffff;
        reset   = 1'b0;
        repeat (6) @(negedge clk);
        rd(16'hbfe2, 8'h00, 1'b1, "arm_iflag0");
        rd(16'hbfe6, 8'h00, 1'b1, "arm_iflag1");
        port_in = 16'h0000;
        repeat (4) @(negedge clk);

        // Legacy alias drives irq/nmi from port0 out bits.
        wr(16'hbffc, 8'h01, 1'b1);
        check("leg_out", 32'(port_out[7:0]), 32'h01);
        check("leg_irq_lat", 32'(irq), 32'h0);
        @(negedge clk);
        check("leg_irq", 32'(irq), 32'h1);
        wr(16'hbffc, 8'h02, 1'b1);
        @(negedge clk);
        check("leg_irq_off", 32'(irq), 32'h0);
        check("leg_nmi", 32'(nmi), 32'h1);
        wr(16'hbffc, 8'h00, 1'b1);
        @(negedge clk);
        check("leg_nmi_off", 32'(nmi), 32'h0);

        // Stalled write must not land.
        wr(16'hbfe1, 8'h5a, 1'b0);
        rd(16'hbfe1, 8'h00, 1'b1, "stall_ddr");
        @(negedge clk);
        wr(16'hbfe1, 8'h5a, 1'b1);
        rd(16'hbfe1, 8'h5a, 1'b1, "ready_ddr");
        check("ready_oe", 32'(port_oe[7:0]), 32'h5a);

        // DATA read mixes out/in per DDR; output bits never flag.
        @(negedge clk);
        wr(16'hbfe1, 8'h0f, 1'b1);
        wr(16'hbfe0, 8'ha5, 1'b1);
        port_in = 16'h003c;
        repeat (4) @(negedge clk);
        rd(16'hbfe0, 8'h35, 1'b1, "mix_data");
        rd(16'hbffc, 8'h35, 1'b1, "mix_legacy");
        rd(16'hbfe2, 8'h30, 1'b1, "mix_iflag0");
        check("mix_out", 32'(port_out[7:0]), 32'ha5);
        @(negedge clk);
        wr(16'hbfe0, 8'h00, 1'b1);
        @(negedge clk);

        rd(16'hbfea, 8'h00, 1'b1, "dec_hole");
        rd(16'hbfdf, 8'h00, 1'b0, "dec_below");
        rd(16'hbfec, 8'h00, 1'b0, "dec_above");

        // Rising edge on bit12 through the synchroniser.
        @(negedge clk);
        wr(16'hbfe7, 8'h10, 1'b1);
        wr(16'hbfe8, 8'h01, 1'b1);
        @(negedge clk);
        check("edge_irq_idle", 32'(irq), 32'h0);
        port_in = 16'h103c;
        @(negedge clk);
        @(negedge clk);
        rd(16'hbfe6, 8'h00, 1'b1, "edge_iflag_2clk");
        @(negedge clk);
        rd(16'hbfe6, 8'h10, 1'b1, "edge_iflag_3clk");
        check("edge_irq_lat", 32'(irq), 32'h0);
        @(negedge clk);
        check("edge_irq", 32'(irq), 32'h1);

        // W1C colliding with a new edge keeps the flag.
        port_in = 16'h003c;
        repeat (4) @(negedge clk);
        rd(16'hbfe6, 8'h10, 1'b1, "fall_no_clear");
        port_in = 16'h103c;
        @(negedge clk);
        @(negedge clk);
        wr(16'hbfe6, 8'h10, 1'b1);
        rd(16'hbfe6, 8'h10, 1'b1, "race_set_wins");
        check("race_irq", 32'(irq), 32'h1);
        wr(16'hbfe6, 8'h10, 1'b1);
        rd(16'hbfe6, 8'h00, 1'b1, "w1c_clear");
        @(negedge clk);
        check("w1c_irq_drop", 32'(irq), 32'h0);

        // Hole writes ignored; SWNMI drives nmi.
        wr(16'hbfe9, 8'hff, 1'b1);
        rd(16'hbfe8, 8'h01, 1'b1, "hole_wr_ignored");
        @(negedge clk);
        wr(16'hbfe8, 8'h03, 1'b1);
        check("swnmi_lat", 32'(nmi), 32'h0);
        @(negedge clk);
        check("swnmi", 32'(nmi), 32'h1);
        rd(16'hbfe8, 8'h03, 1'b1, "ctrl_rd");

        // Reset in the middle of a write clears everything at once and drops the write.
        @(negedge clk);
        address_next = 16'hbfe1;
        data_i       = 8'hff;
        write_next   = 1'b1;
        ready        = 1'b1;
        reset        = 1'b1;
        #1;
        check("mid_rst_oe", 32'(port_oe), 32'h0);
        check("mid_rst_nmi", 32'(nmi), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        @(posedge clk);
        #1;
        check("mid_rst_wr_drop", 32'(port_oe), 32'h0);
        @(negedge clk);
        write_next = 1'b0;
        reset      = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_oe", 32'(port_oe), 32'h0);
        rd(16'hbfe8, 8'h00, 1'b1, "post_rst_ctrl");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
